// File: rtl/mask_randomness_source_if.sv
// Seed/enable/mask bundle between a randomness source and its masked-multiplier consumers.
// Handshake: a seed beat transfers on a rising edge where in_seed_valid && out_seed_ready; in_seed is held stable while valid is high, and out_valid marks out_r/out_p as fresh.
interface mask_randomness_source_if #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_MULS   = 4
);
  localparam int HALF_W = NUM_MULS * (NUM_SHARES * (NUM_SHARES - 1) / 2) * BIT_WIDTH;

  logic [31:0]       in_seed;
  logic              in_seed_valid;
  logic              out_seed_ready;
  logic              in_enable;
  logic [HALF_W-1:0] out_r;
  logic [HALF_W-1:0] out_p;
  logic              out_valid;
  logic              out_reseed_req;
  logic [1:0]        out_state;

  modport master (
    output in_seed, in_seed_valid, in_enable,
    input  out_seed_ready, out_r, out_p, out_valid, out_reseed_req, out_state
  );

  modport slave (
    input  in_seed, in_seed_valid, in_enable,
    output out_seed_ready, out_r, out_p, out_valid, out_reseed_req, out_state
  );
endinterface

// File: rtl/mask_randomness_source.sv
// Seeded bank of 32-bit Galois LFSR lanes supplying r/p masks to parallel masked multipliers.
// Each advance jumps every lane 32 steps so each output bit is fresh per cycle.
package mask_randomness_source_pkg;
  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction
endpackage

module mask_randomness_source
  import mask_randomness_source_pkg::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 4,
  parameter int NUM_MULS      = 4,
  parameter int RESEED_PERIOD = 1024
) (
  input logic                    in_clock,
  input logic                    in_reset,
  mask_randomness_source_if.slave bus
);
  localparam int NUM_QUAD = num_quad(NUM_SHARES);
  localparam int HALF     = NUM_MULS * NUM_QUAD * BIT_WIDTH;
  localparam int OUT_BITS = 2 * HALF;
  localparam int K        = (OUT_BITS + 31) / 32;
  localparam int IDX_W    = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W    = $clog2(RESEED_PERIOD + 1);

  localparam logic [1:0] ST_UNSEEDED = 2'd0;
  localparam logic [1:0] ST_SEEDING  = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  localparam logic [31:0] GOLDEN = 32'h9E3779B9;
  localparam logic [31:0] TAPS   = 32'h80200003;

  logic [1:0]       r_state;
  logic [31:0]      r_lane [K];
  logic [IDX_W-1:0] r_seed_idx;
  logic [CNT_W-1:0] r_adv_cnt;

  logic             w_beat;
  logic             w_last;
  logic [IDX_W-1:0] w_load_idx;
  logic [31:0]      w_mix;
  logic [31:0]      w_seed_val;
  logic [K*32-1:0]  w_cat;

  function automatic logic [31:0] lane_adv(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 32; i++) begin
      t = t[0] ? ((t >> 1) ^ TAPS) : (t >> 1);
    end
    return t;
  endfunction

  assign w_beat     = bus.in_seed_valid && bus.out_seed_ready;
  // UNSEEDED and RUN both (re)start at lane 0; only SEEDING continues from seed_idx.
  assign w_load_idx = (r_state == ST_SEEDING) ? r_seed_idx : '0;
  assign w_last     = (K == 1) || ((r_state == ST_SEEDING) && (r_seed_idx == IDX_W'(K - 1)));
  assign w_mix      = bus.in_seed ^ (32'(w_load_idx) * GOLDEN);
  assign w_seed_val = (w_mix == 32'd0) ? 32'd1 : w_mix;

  always_comb begin
    w_cat = '0;
    for (int k = 0; k < K; k++) begin
      w_cat[k*32 +: 32] = r_lane[k];
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_state    <= ST_UNSEEDED;
      r_seed_idx <= '0;
      r_adv_cnt  <= '0;
      for (int k = 0; k < K; k++) begin
        r_lane[k] <= 32'd0;
      end
    end else if (w_beat) begin
      for (int k = 0; k < K; k++) begin
        if (k == int'(w_load_idx)) begin
          r_lane[k] <= w_seed_val;
        end
      end
      if (w_last) begin
        r_state    <= ST_RUN;
        r_seed_idx <= '0;
        r_adv_cnt  <= '0;
      end else begin
        r_state    <= ST_SEEDING;
        r_seed_idx <= w_load_idx + IDX_W'(1);
      end
    end else if ((r_state == ST_RUN) && bus.in_enable) begin
      for (int k = 0; k < K; k++) begin
        r_lane[k] <= lane_adv(r_lane[k]);
      end
      if (r_adv_cnt != CNT_W'(RESEED_PERIOD)) begin
        r_adv_cnt <= r_adv_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_seed_ready = !in_reset;
  assign bus.out_r          = w_cat[HALF-1:0];
  assign bus.out_p          = w_cat[OUT_BITS-1:HALF];
  assign bus.out_valid      = (r_state == ST_RUN);
  assign bus.out_reseed_req = (r_adv_cnt == CNT_W'(RESEED_PERIOD));
  assign bus.out_state      = r_state;
endmodule

// File: tb/tb_mask_randomness_source.sv
// Bench for mask_randomness_source: K=1 instance (a) with a vector table, K=2 instance (b) with hand sequences.
module tb_mask_randomness_source;
  localparam int W = 66;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  mask_randomness_source_if #(.NUM_SHARES(2), .BIT_WIDTH(4), .NUM_MULS(4)) if_a ();
  mask_randomness_source_if #(.NUM_SHARES(2), .BIT_WIDTH(4), .NUM_MULS(8)) if_b ();

  mask_randomness_source #(
    .NUM_SHARES(2), .BIT_WIDTH(4), .NUM_MULS(4), .RESEED_PERIOD(4)
  ) dut_a (
    .in_clock(clk),
    .in_reset(rst_a),
    .bus     (if_a)
  );

  mask_randomness_source #(
    .NUM_SHARES(2), .BIT_WIDTH(4), .NUM_MULS(8), .RESEED_PERIOD(4)
  ) dut_b (
    .in_clock(clk),
    .in_reset(rst_b),
    .bus     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] seed;
    logic        en;
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] exp_lane;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [31:0] ref_adv(input logic [31:0] s);
    logic [31:0] t;
    logic        lsb;
    t = s;
    for (int i = 0; i < 32; i++) begin
      lsb = t[0];
      t   = t >> 1;
      if (lsb) t = t ^ 32'h80200003;
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] obs_a();
    return {32'd0, if_a.out_valid, if_a.out_reseed_req, if_a.out_p, if_a.out_r};
  endfunction

  function automatic logic [W-1:0] obs_b();
    return {if_b.out_valid, if_b.out_reseed_req, if_b.out_p, if_b.out_r};
  endfunction

  task automatic step_a(input string name, input logic sv, input logic [31:0] seed,
                        input logic en, input logic v, input logic req, input logic [31:0] lane);
    if_a.in_seed_valid = sv;
    if_a.in_seed       = seed;
    if_a.in_enable     = en;
    exp_q.push_back({32'd0, v, req, lane});
    @(posedge clk);
    #1;
    check(name, obs_a(), exp_q.pop_front());
    if_a.in_seed_valid = 1'b0;
    if_a.in_enable     = 1'b0;
  endtask

  task automatic step_b(input string name, input logic sv, input logic [31:0] seed,
                        input logic en, input logic v, input logic req,
                        input logic [31:0] l1, input logic [31:0] l0);
    if_b.in_seed_valid = sv;
    if_b.in_seed       = seed;
    if_b.in_enable     = en;
    exp_q.push_back({v, req, l1, l0});
    @(posedge clk);
    #1;
    check(name, obs_b(), exp_q.pop_front());
    if_b.in_seed_valid = 1'b0;
    if_b.in_enable     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b0;
    logic [31:0] b1;
    checks = 0;
    errors = 0;
    if_a.in_seed = 32'd0; if_a.in_seed_valid = 1'b0; if_a.in_enable = 1'b0;
    if_b.in_seed = 32'd0; if_b.in_seed_valid = 1'b0; if_b.in_enable = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset state
    #3;
    check("reset_outputs_a", obs_a(), '0);
    check("reset_ready_a", {65'd0, if_a.out_seed_ready}, '0);
    check("reset_state_a", {64'd0, if_a.out_state}, '0);
    check("reset_outputs_b", obs_b(), '0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("ready_after_reset", {65'd0, if_a.out_seed_ready}, {65'd0, 1'b1});

    // Enable before any seed is ignored
    for (int i = 0; i < 10; i++) begin
      step_a($sformatf("unseeded_en_%0d", i), 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    end

    a = 32'd1;
    tbl[0]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h12345678};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678};
    tbl[2]  = '{1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000001};
    for (int i = 3; i <= 7; i++) begin
      a = ref_adv(a);
      tbl[i] = '{1'b0, 32'h0, 1'b1, 1'b1, (i >= 6), a};
    end
    tbl[8]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, ref_adv(32'hDEADBEEF)};

    for (int i = 0; i < 11; i++) begin
      step_a($sformatf("vec_%0d", i), tbl[i].sv, tbl[i].seed, tbl[i].en,
             tbl[i].exp_valid, tbl[i].exp_req, tbl[i].exp_lane);
    end

    // Reset mid-run discards the lane immediately
    rst_a = 1'b1;
    #1;
    check("midrun_reset_a", obs_a(), '0);
    @(negedge clk);
    rst_a = 1'b0;
    step_a("post_reset_en_a", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    step_a("post_reset_seed_a", 1'b1, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000005);

    // K=2: reset between the beats forces a fresh two-beat seeding
    step_b("b_beat0", 1'b1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 32'd0, 32'h000000FF);
    rst_b = 1'b1;
    #1;
    check("b_reset_between", obs_b(), '0);
    check("b_reset_state", {64'd0, if_b.out_state}, '0);
    @(negedge clk);
    rst_b = 1'b0;
    b0 = 32'h11111111;
    b1 = 32'h22222222 ^ 32'h9E3779B9;
    step_b("b_fresh_beat0", 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'd0, b0);
    step_b("b_fresh_beat1", 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, b1, b0);
    b0 = ref_adv(b0);
    b1 = ref_adv(b1);
    step_b("b_advance", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, b1, b0);
    step_b("b_reseed_beat0", 1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0, b1, 32'h00000005);
    step_b("b_zero_mix_beat1", 1'b1, 32'h9E3779B9, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'h00000005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mask_randomness_source.md
MASK_RANDOMNESS_SOURCE -- requirements
Module: mask_randomness_source

Interface
REQ-001 Parameter NUM_SHARES, default 2: share count of the consuming masked multipliers.
REQ-002 Parameter BIT_WIDTH, default 4: bit width of one mask element.
REQ-003 Parameter NUM_MULS, default 4: number of masked multipliers supplied in parallel.
REQ-004 Parameter RESEED_PERIOD, default 1024: advances allowed before a reseed is requested; legal range 1..2^20.
REQ-005 Derived NUM_QUAD = NUM_SHARES*(NUM_SHARES-1)/2, using the package num_quad function; OUT_BITS = 2*NUM_MULS*NUM_QUAD*BIT_WIDTH; K = ceil(OUT_BITS/32).
REQ-006 in_clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 in_reset  input  1  asynchronous, active-high reset.
REQ-008 in_seed  input  32  seed word for one lane.
REQ-009 in_seed_valid  input  1  in_seed is valid this cycle.
REQ-010 out_seed_ready  output  1  a seed beat is accepted this cycle.
REQ-011 in_enable  input  1  advance all lanes this cycle.
REQ-012 out_r  output  NUM_MULS x NUM_QUAD x BIT_WIDTH  per-multiplier r masks (in_r of the consumer).
REQ-013 out_p  output  NUM_MULS x NUM_QUAD x BIT_WIDTH  per-multiplier p masks (in_p of the consumer).
REQ-014 out_valid  output  1  out_r and out_p hold fresh, seeded randomness.
REQ-015 out_reseed_req  output  1  the reseed period is exhausted.

Function
REQ-016 State: K 32-bit lanes L[0..K-1], FSM {UNSEEDED, SEEDING, RUN}, lane index seed_idx (0..K-1), advance counter adv_cnt.
REQ-017 Lane step: lsb = s[0]; s = s >> 1; if lsb = 1 then s ^= 32'h80200003. One advance applies 32 consecutive steps to every lane within one cycle.
REQ-018 Output mapping: concatenate {L[K-1],...,L[0]} and take the low OUT_BITS bits. The low half feeds out_r and the high half feeds out_p. Within each half, multiplier m, pair q occupies bits [(m*NUM_QUAD+q)*BIT_WIDTH +: BIT_WIDTH].
REQ-019 out_r and out_p are driven directly from lane registers, with no combinational path from any input.
REQ-020 out_seed_ready is 1 in every state when not in reset; a beat is in_seed_valid AND out_seed_ready.
REQ-021 Seed load: on a beat, L[seed_idx] <= in_seed XOR (seed_idx * 32'h9E3779B9, modulo 2^32). If that value is 0, the lane loads 32'h00000001 instead.
REQ-022 UNSEEDED: on a beat, load lane 0. If K = 1, go to RUN; otherwise set seed_idx = 1 and go to SEEDING.
REQ-023 SEEDING: on a beat, load L[seed_idx]. If seed_idx = K-1, go to RUN; otherwise increment seed_idx.
REQ-024 RUN: a beat restarts seeding at lane 0 with the same rules as UNSEEDED.
REQ-025 Entering RUN clears adv_cnt to 0 and clears out_reseed_req.
REQ-026 out_valid is 1 exactly when the FSM is in RUN. The first valid cycle is the cycle after the final seed beat.
REQ-027 in_enable takes effect only in RUN with no beat in the same cycle; it is ignored otherwise.
REQ-028 A beat in the same cycle as in_enable in RUN: the beat wins and the lanes do not advance.
REQ-029 With in_enable = 0, the lanes hold, so the consumer sees the same masks.
REQ-030 Each effective advance increments adv_cnt, saturating at RESEED_PERIOD.
REQ-031 out_reseed_req is 1 when adv_cnt = RESEED_PERIOD. Advances continue while it is set.
REQ-032 A lane never holds 0 after seeding.

Reset
REQ-033 Asserting in_reset immediately forces: state UNSEEDED, all lanes 0, seed_idx 0, adv_cnt 0, out_valid 0, out_reseed_req 0, out_r 0, out_p 0.
REQ-034 out_seed_ready is 0 while in_reset is high.
REQ-035 Reset asserted mid-seeding or mid-run discards all partial state; a full K-beat seeding is required afterwards.

Verification (NUM_SHARES=2, BIT_WIDTH=4, NUM_MULS=4, so K=1; RESEED_PERIOD=4)
REQ-036 Reset, then one beat with in_seed = 32'h12345678 -> next cycle out_valid = 1, out_r = 16'h5678, out_p = 16'h1234.
REQ-037 Beat with in_seed = 0 -> lane = 32'h00000001, out_r = 16'h0001, out_p = 16'h0000.
REQ-038 After seeding with 32'h1, hold in_enable = 1 for 4 cycles -> the outputs match a reference model of REQ-017 every cycle; out_reseed_req rises after the 4th advance and stays high on a 5th.
REQ-039 In RUN, in_enable = 1 together with a beat of 32'hDEADBEEF -> no advance, lane = 32'hDEADBEEF, out_reseed_req = 0.
REQ-040 Before any seed, in_enable = 1 for 10 cycles -> out_valid = 0, outputs stay 0.
REQ-041 Configuration NUM_MULS = 8 (K = 2): 2 beats are required; out_valid = 0 after the 1st beat; assert reset between the beats -> UNSEEDED, and 2 fresh beats are needed.
